fft_output_reorder: RTL

//  Output stage of the 64-point FFT. Sits directly downstream of the second 8-point FFT stage.
//  - Captures eight 8-lane result groups (64 complex points) into a ping-pong register buffer.
//  - Streams the points out one 32-bit word per cycle, in natural index order 0..63.
//  - Drives the top-level Out_Stream / Data_Out pair.

---
 rtl/fft_pkg.sv | 35 +++
 rtl/fft_output_reorder_if.sv | 24 ++
 rtl/fft_out_bank.sv | 25 ++
 rtl/fft_output_reorder.sv | 129 ++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the 64-point FFT output stage.
// Holds the round-half-up/saturate helper used when FFT_OUT_SCALE_EN is defined.
package fft_pkg;

  localparam int FFT_DW          = 32;
  localparam int FFT_LANES       = 8;
  localparam int FFT_GROUPS      = 8;
  localparam int FFT_N           = FFT_LANES * FFT_GROUPS;
  localparam int FFT_SCALE_SHIFT = 6;

  typedef struct packed {
    logic signed [FFT_DW/2-1:0] re;
    logic signed [FFT_DW/2-1:0] im;
  } cplx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rd_state_t;

  // (x + 2^(S-1)) >>> S, clamped to the signed 16-bit range
  function automatic logic [15:0] scale_comp(input logic [15:0] x);
    logic signed [16:0] w_sum;
    logic signed [16:0] w_shr;
    w_sum = $signed({x[15], x}) + (17'sd1 <<< (FFT_SCALE_SHIFT - 1));
    w_shr = w_sum >>> FFT_SCALE_SHIFT;
    if (w_shr > 17'sd32767)
      return 16'h7FFF;
    else if (w_shr < -17'sd32768)
      return 16'h8000;
    else
      return w_shr[15:0];
  endfunction

endpackage

// File: rtl/fft_output_reorder_if.sv
// Group-in / sample-out bus of the FFT output reorder stage.
// slave: the reorder block; master: the upstream FFT stage plus downstream sink.
interface fft_output_reorder_if;
  import fft_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [FFT_DW-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [FFT_DW-1:0] out_stream;
  logic              out_valid;
  logic              out_first;
  logic              out_last;

  modport slave (
    input  in_valid, D0, D1, D2, D3, D4, D5, D6, D7,
    output in_ready, out_stream, out_valid, out_first, out_last
  );

  modport master (
    output in_valid, D0, D1, D2, D3, D4, D5, D6, D7,
    input  in_ready, out_stream, out_valid, out_first, out_last
  );

endinterface

// File: rtl/fft_out_bank.sv
// One 64-point register bank: 8-lane group write (lane L of group G -> 8L+G), 1-wide read.
// Contents carry no reset; validity is tracked by the full flags in the parent.
module fft_out_bank
  import fft_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [2:0]        i_grp,
  input  logic [FFT_DW-1:0] i_lanes [FFT_LANES],
  input  logic [5:0]        i_raddr,
  output logic [FFT_DW-1:0] o_rdata
);

  logic [FFT_DW-1:0] r_mem [FFT_N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int l = 0; l < FFT_LANES; l++)
        r_mem[{l[2:0], i_grp}] <= i_lanes[l];
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_output_reorder.sv
// Ping-pong reorder buffer: captures 8 transposed groups, streams points 0..63 in order.
// Optional output scaling is enabled by defining FFT_OUT_SCALE_EN.
module fft_output_reorder
  import fft_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  fft_output_reorder_if.slave   bus
);

  logic [FFT_DW-1:0] w_lanes [FFT_LANES];
  logic [FFT_DW-1:0] w_rdata0, w_rdata1;
  cplx_t             w_rd_c, w_out_nxt;

  logic [1:0] r_full;
  logic       r_wr_bank, r_rd_bank;
  logic [2:0] r_grp;
  logic [5:0] r_rd_n;
  rd_state_t  r_state;
  cplx_t      r_out;
  logic       r_out_valid, r_out_first, r_out_last;

  rd_state_t  w_state_nxt;
  logic [5:0] w_rd_n_nxt;
  logic       w_rd_done, w_out_valid_nxt, w_out_first_nxt, w_out_last_nxt;
  logic       w_accept, w_fill_done;
  logic [1:0] w_set_mask, w_clr_mask;

  assign w_lanes[0] = bus.D0;
  assign w_lanes[1] = bus.D1;
  assign w_lanes[2] = bus.D2;
  assign w_lanes[3] = bus.D3;
  assign w_lanes[4] = bus.D4;
  assign w_lanes[5] = bus.D5;
  assign w_lanes[6] = bus.D6;
  assign w_lanes[7] = bus.D7;

  assign bus.in_ready = ~r_full[r_wr_bank];
  assign w_accept     = bus.in_valid & ~r_full[r_wr_bank];
  assign w_fill_done  = w_accept & (r_grp == 3'd7);

  fft_out_bank u_bank0 (
    .clk     (clk),
    .i_we    (w_accept & ~r_wr_bank),
    .i_grp   (r_grp),
    .i_lanes (w_lanes),
    .i_raddr (r_rd_n),
    .o_rdata (w_rdata0)
  );

  fft_out_bank u_bank1 (
    .clk     (clk),
    .i_we    (w_accept & r_wr_bank),
    .i_grp   (r_grp),
    .i_lanes (w_lanes),
    .i_raddr (r_rd_n),
    .o_rdata (w_rdata1)
  );

  assign w_rd_c = r_rd_bank ? w_rdata1 : w_rdata0;

`ifdef FFT_OUT_SCALE_EN
  assign w_out_nxt = {scale_comp(w_rd_c.re), scale_comp(w_rd_c.im)};
`else
  assign w_out_nxt = w_rd_c;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_rd_n_nxt      = r_rd_n;
    w_rd_done       = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_out_first_nxt = 1'b0;
    w_out_last_nxt  = 1'b0;
    if (r_state == IDLE) begin
      if (r_full[r_rd_bank]) begin
        w_state_nxt = DRAIN;
        w_rd_n_nxt  = 6'd0;
      end
    end else begin
      w_out_valid_nxt = 1'b1;
      w_out_first_nxt = (r_rd_n == 6'd0);
      w_out_last_nxt  = (r_rd_n == 6'd63);
      w_rd_n_nxt      = r_rd_n + 6'd1;
      if (r_rd_n == 6'd63) begin
        w_rd_done = 1'b1;
        // the other bank already full: keep draining with no gap cycle
        if (!r_full[~r_rd_bank])
          w_state_nxt = IDLE;
      end
    end
  end

  assign w_set_mask = w_fill_done ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr_mask = w_rd_done   ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full      <= 2'b00;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_grp       <= 3'd0;
      r_rd_n      <= 6'd0;
      r_state     <= IDLE;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_out_first <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_full      <= (r_full | w_set_mask) & ~w_clr_mask;
      r_grp       <= w_accept ? r_grp + 3'd1 : r_grp;
      r_wr_bank   <= r_wr_bank ^ w_fill_done;
      r_rd_bank   <= r_rd_bank ^ w_rd_done;
      r_rd_n      <= w_rd_n_nxt;
      r_state     <= w_state_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_first <= w_out_first_nxt;
      r_out_last  <= w_out_last_nxt;
      if (r_state == DRAIN)
        r_out <= w_out_nxt;
    end
  end

  assign bus.out_stream = r_out;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_first  = r_out_first;
  assign bus.out_last   = r_out_last;

endmodule
